prim_fifo_sync_rdctl: RTL

PRIM_FIFO_SYNC_RDCTL -- requirements
Module: prim_fifo_sync_rdctl

---
 rtl/prim_fifo_sync_rdctl.sv | 97 +++++++++
 1 files changed

// File: rtl/prim_fifo_sync_rdctl.sv
// Read-side control for a synchronous FIFO: read pointer, occupancy, flags,
// watermark tracking and a sticky pointer-consistency error.
module prim_fifo_sync_rdctl #(
  parameter int Depth = 4,
  parameter int PtrW  = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic [PtrW-1:0] wptr_i,
  input  logic            rready_i,
  input  logic [PtrW-1:0] thresh_i,
  output logic            rvalid_o,
  output logic [PtrW-2:0] raddr_o,
  output logic [PtrW-1:0] rptr_o,
  output logic [PtrW-1:0] depth_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            thresh_o,
  output logic [PtrW-1:0] hiwat_o,
  output logic            err_o
);

  localparam logic [PtrW-1:0] DepthP  = PtrW'(Depth);
  localparam logic [PtrW-2:0] LastIdx = (PtrW-1)'(Depth - 1);

  logic [PtrW-1:0] r_rptr;
  logic            r_thresh;
  logic [PtrW-1:0] r_hiwat;
  logic            r_err;

  logic [PtrW-2:0] w_widx;
  logic [PtrW-2:0] w_ridx;
  logic            w_wph;
  logic            w_rph;
  logic [PtrW-1:0] w_depth;
  logic            w_illegal;
  logic            w_empty;
  logic            w_pop;
  logic [PtrW-1:0] w_rptr_next;

  assign w_widx = wptr_i[PtrW-2:0];
  assign w_ridx = r_rptr[PtrW-2:0];
  assign w_wph  = wptr_i[PtrW-1];
  assign w_rph  = r_rptr[PtrW-1];

  // Differing phases mean the writer has wrapped once more than the reader.
  assign w_depth = (w_wph == w_rph) ? ({1'b0, w_widx} - {1'b0, w_ridx})
                                    : (DepthP - {1'b0, w_ridx} + {1'b0, w_widx});

  assign w_illegal = (w_depth > DepthP) ||
                     ({1'b0, w_widx} >= DepthP) ||
                     ({1'b0, w_ridx} >= DepthP);

  assign w_empty = (w_depth == '0);
  assign w_pop   = rvalid_o & rready_i;

  // Non-power-of-two depths need an explicit wrap back to index 0.
  assign w_rptr_next = (w_ridx == LastIdx) ? {~w_rph, {(PtrW-1){1'b0}}}
                                           : r_rptr + PtrW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rptr   <= '0;
      r_thresh <= 1'b0;
      r_hiwat  <= '0;
      r_err    <= 1'b0;
    end else if (clr_i) begin
      r_rptr   <= '0;
      r_thresh <= 1'b0;
      r_hiwat  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rptr <= w_rptr_next;
      end
      r_thresh <= (w_depth >= thresh_i);
      if (w_depth > r_hiwat) begin
        r_hiwat <= w_depth;
      end
      if (w_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rptr_o   = r_rptr;
  assign raddr_o  = w_ridx;
  assign depth_o  = w_depth;
  assign empty_o  = w_empty;
  assign full_o   = (w_depth == DepthP);
  assign rvalid_o = ~w_empty & ~r_err;
  assign thresh_o = r_thresh;
  assign hiwat_o  = r_hiwat;
  assign err_o    = r_err;

endmodule
